// File: rtl/lcd_command_sequencer.sv
// HD44780 character-LCD sequencer behind a Nios II multi-cycle custom instruction.
// Runs the power-up init ROM, then serialises CPU instruction/data bytes with tAS/PWeh/tAH and execution waits.
module lcd_command_sequencer #(
    parameter int SETUP_CYC   = 4,
    parameter int PULSE_CYC   = 25,
    parameter int HOLD_CYC    = 4,
    parameter int SHORT_WAIT  = 2000,
    parameter int LONG_WAIT   = 82000,
    parameter int POWERUP_CYC = 750000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clk_en,
    input  logic        i_start,
    input  logic [31:0] i_dataa,
    input  logic [31:0] i_datab,
    output logic [31:0] o_result,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_lcd_enable,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);

    // state     | meaning
    // PWR_WAIT  | post-reset delay before the first init byte
    // INIT_LOAD | fetch the next init ROM byte onto the bus
    // SETUP     | RS/DATA stable, E low
    // PULSE     | E high
    // HOLD      | RS/DATA held after E falls
    // WAIT      | LCD execution time for the byte just written
    // DONE      | one-cycle completion pulse to the CPU
    // IDLE      | ready for a CPU request
    localparam logic [2:0] S_PWR_WAIT  = 3'd0;
    localparam logic [2:0] S_INIT_LOAD = 3'd1;
    localparam logic [2:0] S_SETUP     = 3'd2;
    localparam logic [2:0] S_PULSE     = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;
    localparam logic [2:0] S_WAIT      = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_IDLE      = 3'd7;

    localparam int MAX_1   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_2   = (MAX_1 > HOLD_CYC) ? MAX_1 : HOLD_CYC;
    localparam int MAX_3   = (MAX_2 > SHORT_WAIT) ? MAX_2 : SHORT_WAIT;
    localparam int MAX_4   = (MAX_3 > LONG_WAIT) ? MAX_3 : LONG_WAIT;
    localparam int MAX_CYC = (MAX_4 > POWERUP_CYC) ? MAX_4 : POWERUP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(SHORT_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(POWERUP_CYC - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lcd_enable;
    logic             r_lcd_rs;
    logic [7:0]       r_lcd_data;
    logic             r_init_done;
    logic             r_in_init;
    logic [1:0]       r_rom_idx;
    logic             r_ci_init;
    logic             r_pend_vld;
    logic [9:0]       r_pend;

    logic             w_cnt_zero;
    logic             w_last_init;
    logic             w_init_end;
    logic             w_take;
    logic [9:0]       w_req;
    logic             w_capture;
    logic             w_long;
    logic             w_unused;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h06;
            default: b = 8'h01;
        endcase
        return b;
    endfunction

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_last_init = r_in_init && (r_rom_idx == 2'd3);
    assign w_init_end  = (r_state == S_WAIT) && w_cnt_zero && w_last_init;
    // A request is dispatched from IDLE, or from the pending slot when init finishes
    assign w_take      = ((r_state == S_IDLE) && i_start) || (w_init_end && r_pend_vld);
    assign w_req       = (r_state == S_IDLE) ? i_dataa[9:0] : r_pend;
    assign w_capture   = i_start && (r_state != S_IDLE) && ((r_state == S_PWR_WAIT) || r_in_init);
    assign w_long      = !r_lcd_rs && (r_lcd_data[7:2] == 6'd0) && (r_lcd_data != 8'd0);
    assign w_unused    = ^{i_datab, i_dataa[31:10]};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_PWR_WAIT;
            r_cnt        <= LD_PWR;
            r_lcd_enable <= 1'b0;
            r_lcd_rs     <= 1'b0;
            r_lcd_data   <= 8'd0;
            r_init_done  <= 1'b0;
            r_in_init    <= 1'b0;
            r_rom_idx    <= 2'd0;
            r_ci_init    <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_pend       <= 10'd0;
        end else if (i_clk_en) begin
            if (w_capture) begin
                r_pend     <= i_dataa[9:0];
                r_pend_vld <= 1'b1;
            end
            if (!w_cnt_zero) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            case (r_state)
                S_PWR_WAIT: begin
                    if (w_cnt_zero) begin
                        r_state   <= S_INIT_LOAD;
                        r_in_init <= 1'b1;
                        r_rom_idx <= 2'd0;
                    end
                end
                S_INIT_LOAD: begin
                    r_lcd_rs   <= 1'b0;
                    r_lcd_data <= init_byte(r_rom_idx);
                    r_state    <= S_SETUP;
                    r_cnt      <= LD_SETUP;
                end
                S_SETUP: begin
                    if (w_cnt_zero) begin
                        r_state      <= S_PULSE;
                        r_cnt        <= LD_PULSE;
                        r_lcd_enable <= 1'b1;
                    end
                end
                S_PULSE: begin
                    if (w_cnt_zero) begin
                        r_state      <= S_HOLD;
                        r_cnt        <= LD_HOLD;
                        r_lcd_enable <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_zero) begin
                        r_state <= S_WAIT;
                        r_cnt   <= w_long ? LD_LONG : LD_SHORT;
                    end
                end
                S_WAIT: begin
                    if (w_cnt_zero) begin
                        if (!r_in_init) begin
                            r_state <= S_DONE;
                        end else if (!w_last_init) begin
                            r_rom_idx <= r_rom_idx + 2'd1;
                            r_state   <= S_INIT_LOAD;
                        end else begin
                            r_init_done <= 1'b1;
                            r_in_init   <= 1'b0;
                            r_ci_init   <= 1'b0;
                            r_state     <= r_ci_init ? S_DONE : S_IDLE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_IDLE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            // Dispatch overrides the per-state updates above
            if (w_take) begin
                r_pend_vld <= 1'b0;
                case (w_req[9:8])
                    2'b00, 2'b01: begin
                        r_lcd_rs   <= w_req[8];
                        r_lcd_data <= w_req[7:0];
                        r_state    <= S_SETUP;
                        r_cnt      <= LD_SETUP;
                    end
                    2'b10: begin
                        r_init_done <= 1'b0;
                        r_in_init   <= 1'b1;
                        r_rom_idx   <= 2'd0;
                        r_ci_init   <= 1'b1;
                        r_state     <= S_INIT_LOAD;
                    end
                    default: r_state <= S_DONE;
                endcase
            end
        end
    end

    assign o_result     = {23'd0, r_init_done, r_lcd_data};
    assign o_done       = (r_state == S_DONE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_lcd_enable = r_lcd_enable;
    assign o_lcd_rs     = r_lcd_rs;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_data   = r_lcd_data;

endmodule

// File: tb/tb_lcd_command_sequencer.sv
// Self-checking bench for lcd_command_sequencer: a negedge monitor logs E pulses and done
// pulses, and each scenario task compares them with timings computed from the command rules.
module tb_lcd_command_sequencer;

    localparam int SETUP = 2;
    localparam int PULSE = 3;
    localparam int HOLD  = 2;
    localparam int SHORT = 10;
    localparam int LONG  = 40;
    localparam int PWR   = 50;

    typedef struct {
        int         rise;
        int         width;
        logic [7:0] data;
        logic       rs;
        logic       stable;
    } pulse_t;

    typedef struct {
        int          stamp;
        logic [31:0] res;
    } done_t;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        lcd_enable;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    int     cyc = 0;
    int     tests_run = 0;
    int     tests_failed = 0;
    int     id_rise = -1;
    pulse_t pq[$];
    pulse_t epq[$];
    done_t  dq[$];
    logic [7:0] rom [4];

    lcd_command_sequencer #(
        .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD),
        .SHORT_WAIT(SHORT), .LONG_WAIT(LONG), .POWERUP_CYC(PWR)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(clk_en), .i_start(start),
        .i_dataa(dataa), .i_datab(datab), .o_result(result), .o_done(done),
        .o_busy(busy), .o_lcd_enable(lcd_enable), .o_lcd_rs(lcd_rs),
        .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    // Monitor: stamps are the posedge count at the sampling negedge
    initial begin
        pulse_t cur;
        logic   prev_e;
        logic   prev_id;
        prev_e  = 1'b0;
        prev_id = 1'b0;
        cur     = '{0, 0, 8'h00, 1'b0, 1'b1};
        forever begin
            @(negedge clk);
            if (lcd_enable === 1'b1 && !prev_e) begin
                cur = '{cyc, 0, lcd_data, lcd_rs, 1'b1};
            end else if (lcd_enable === 1'b1) begin
                if (lcd_data !== cur.data || lcd_rs !== cur.rs) cur.stable = 1'b0;
            end else if (prev_e) begin
                cur.width = cyc - cur.rise;
                pq.push_back(cur);
            end
            prev_e = (lcd_enable === 1'b1);
            if (done === 1'b1) dq.push_back('{cyc, result});
            if (result[8] === 1'b1 && !prev_id) id_rise = cyc;
            prev_id = (result[8] === 1'b1);
        end
    end

    function automatic int exp_wait(input logic rs, input logic [7:0] b);
        return (!rs && b != 8'd0 && b < 8'd4) ? LONG : SHORT;
    endfunction

    // Expected init pulses when the first ROM byte is loaded at stamp l0; returns the init-complete stamp
    task automatic model_init(input int l0, output int end_s);
        int l;
        l = l0;
        for (int i = 0; i < 4; i++) begin
            epq.push_back('{l + 1 + SETUP, PULSE, rom[i], 1'b0, 1'b1});
            l += 1 + SETUP + PULSE + HOLD + exp_wait(1'b0, rom[i]);
        end
        end_s = l;
    endtask

    task automatic model_write(input int s, input logic rs, input logic [7:0] b, output int d);
        epq.push_back('{s + 1 + SETUP, PULSE, b, rs, 1'b1});
        d = s + 1 + SETUP + PULSE + HOLD + exp_wait(rs, b);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] b, output int s);
        @(negedge clk);
        start       = 1'b1;
        dataa       = $urandom();
        dataa[9:0]  = {op, b};
        datab       = $urandom();
        s           = cyc;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic clear_logs();
        pq.delete();
        epq.delete();
        dq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({lcd_enable, lcd_rs, lcd_rw, lcd_data} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_pins: got E=%b rs=%b rw=%b data=%h expected all 0", lcd_enable, lcd_rs, lcd_rw, lcd_data);
        end
        tests_run++;
        if (result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
    endtask

    task automatic release_and_check_init(input string tag);
        int r;
        int e;
        @(negedge clk);
        rst_n   = 1'b1;
        r       = cyc;
        id_rise = -1;
        clear_logs();
        model_init(r + PWR, e);
        while (cyc < e + 3) @(negedge clk);
        tests_run++;
        if (pq.size() != 4) begin
            tests_failed++;
            $display("FAIL %s_pulse_count: got %0d expected 4", tag, pq.size());
        end
        for (int i = 0; i < pq.size() && i < 4; i++) begin
            tests_run++;
            if (pq[i].rise != epq[i].rise || pq[i].width != epq[i].width || pq[i].data !== epq[i].data ||
                pq[i].rs !== epq[i].rs || pq[i].stable !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s_pulse%0d: got rise=%0d w=%0d data=%h rs=%b stable=%b expected rise=%0d w=%0d data=%h rs=%b",
                         tag, i, pq[i].rise, pq[i].width, pq[i].data, pq[i].rs, pq[i].stable,
                         epq[i].rise, epq[i].width, epq[i].data, epq[i].rs);
            end
        end
        tests_run++;
        if (id_rise != e) begin
            tests_failed++;
            $display("FAIL %s_init_done_rise: got %0d expected %0d", tag, id_rise, e);
        end
        tests_run++;
        if (dq.size() != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_quiet_end: got dones=%0d busy=%b expected dones=0 busy=0", tag, dq.size(), busy);
        end
    endtask

    task automatic test_init();
        release_and_check_init("init");
    endtask

    task automatic test_write();
        int s;
        int d;
        clear_logs();
        issue(2'b01, 8'h41, s);
        model_write(s, 1'b1, 8'h41, d);
        while (cyc < s + 5) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_busy: got %b expected 1", busy);
        end
        while (cyc < d + 4) @(negedge clk);
        tests_run++;
        if (dq.size() != 1 || dq[0].stamp != s + 18 || dq[0].res !== 32'h141) begin
            tests_failed++;
            $display("FAIL write_done: got n=%0d stamp=%0d res=%h expected n=1 stamp=%0d res=00000141",
                     dq.size(), (dq.size() > 0) ? dq[0].stamp : -1, (dq.size() > 0) ? dq[0].res : 32'hx, s + 18);
        end
        tests_run++;
        if (pq.size() != 1 || pq[0].rise != epq[0].rise || pq[0].width != PULSE || pq[0].data !== 8'h41 || pq[0].rs !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_pulse: got n=%0d expected one pulse rise=%0d data=41 rs=1", pq.size(), epq[0].rise);
        end
        tests_run++;
        if (result !== 32'h141 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_result_hold: got res=%h busy=%b expected res=00000141 busy=0", result, busy);
        end
    endtask

    task automatic test_status_reinit();
        int s1;
        int s2;
        int e;
        clear_logs();
        issue(2'b11, $urandom(), s1);
        issue(2'b10, $urandom(), s2);
        model_init(s2 + 1, e);
        while (cyc < s2 + 10) @(negedge clk);
        tests_run++;
        if (result[8] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reinit_init_done_low: got %b expected 0", result[8]);
        end
        while (cyc < e + 3) @(negedge clk);
        tests_run++;
        if (dq.size() != 2 || dq[0].stamp != s1 + 1 || dq[0].res !== 32'h141) begin
            tests_failed++;
            $display("FAIL status_done: got n=%0d stamp=%0d res=%h expected stamp=%0d res=00000141",
                     dq.size(), (dq.size() > 0) ? dq[0].stamp : -1, (dq.size() > 0) ? dq[0].res : 32'hx, s1 + 1);
        end
        tests_run++;
        if (dq.size() != 2 || dq[1].stamp != e || dq[1].res !== 32'h101) begin
            tests_failed++;
            $display("FAIL reinit_done: got n=%0d stamp=%0d res=%h expected stamp=%0d res=00000101",
                     dq.size(), (dq.size() > 1) ? dq[1].stamp : -1, (dq.size() > 1) ? dq[1].res : 32'hx, e);
        end
        tests_run++;
        if (pq.size() != 4) begin
            tests_failed++;
            $display("FAIL reinit_pulse_count: got %0d expected 4", pq.size());
        end
        for (int i = 0; i < pq.size() && i < 4; i++) begin
            tests_run++;
            if (pq[i].rise != epq[i].rise || pq[i].width != PULSE || pq[i].data !== epq[i].data || pq[i].rs !== 1'b0) begin
                tests_failed++;
                $display("FAIL reinit_pulse%0d: got rise=%0d w=%0d data=%h rs=%b expected rise=%0d data=%h rs=0",
                         i, pq[i].rise, pq[i].width, pq[i].data, pq[i].rs, epq[i].rise, epq[i].data);
            end
        end
    endtask

    task automatic test_random_writes();
        logic [1:0]  op;
        logic [7:0]  b;
        logic [7:0]  last;
        logic [31:0] exp_res;
        int          s;
        int          d;
        last = 8'h01;
        for (int k = 0; k < 12; k++) begin
            op = ($urandom_range(0, 3) == 3) ? 2'b11 : 2'($urandom_range(0, 1));
            b  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom());
            clear_logs();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(op, b, s);
            if (op == 2'b11) begin
                d       = s + 1;
                exp_res = {23'd0, 1'b1, last};
            end else begin
                model_write(s, op[0], b, d);
                exp_res = {23'd0, 1'b1, b};
                last    = b;
            end
            while (cyc < d + 2) @(negedge clk);
            tests_run++;
            if (dq.size() != 1 || dq[0].stamp != d || dq[0].res !== exp_res) begin
                tests_failed++;
                $display("FAIL rand%0d_done: op=%b byte=%h got n=%0d stamp=%0d res=%h expected stamp=%0d res=%h",
                         k, op, b, dq.size(), (dq.size() > 0) ? dq[0].stamp : -1,
                         (dq.size() > 0) ? dq[0].res : 32'hx, d, exp_res);
            end
            tests_run++;
            if (pq.size() != epq.size() ||
                (epq.size() == 1 && (pq[0].rise != epq[0].rise || pq[0].width != PULSE ||
                                     pq[0].data !== b || pq[0].rs !== op[0] || pq[0].stable !== 1'b1))) begin
                tests_failed++;
                $display("FAIL rand%0d_pulse: op=%b byte=%h got n=%0d expected n=%0d rise=%0d",
                         k, op, b, pq.size(), epq.size(), (epq.size() > 0) ? epq[0].rise : -1);
            end
        end
    endtask

    task automatic test_clk_en_freeze();
        int         s;
        int         d;
        logic [7:0] b;
        b = $urandom();
        clear_logs();
        issue(2'b01, b, s);
        model_write(s, 1'b1, b, d);
        while (cyc < s + 4) @(negedge clk);
        clk_en = 1'b0;
        while (cyc < s + 9) @(negedge clk);
        clk_en = 1'b1;
        while (cyc < d + 5 + 3) @(negedge clk);
        tests_run++;
        if (pq.size() != 1 || pq[0].rise != s + 1 + SETUP || pq[0].width != PULSE + 5 || pq[0].stable !== 1'b1) begin
            tests_failed++;
            $display("FAIL freeze_pulse: got n=%0d rise=%0d w=%0d expected rise=%0d w=%0d",
                     pq.size(), (pq.size() > 0) ? pq[0].rise : -1, (pq.size() > 0) ? pq[0].width : -1,
                     s + 1 + SETUP, PULSE + 5);
        end
        tests_run++;
        if (dq.size() != 1 || dq[0].stamp != d + 5) begin
            tests_failed++;
            $display("FAIL freeze_done: got n=%0d stamp=%0d expected stamp=%0d",
                     dq.size(), (dq.size() > 0) ? dq[0].stamp : -1, d + 5);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int s;
        clear_logs();
        issue(2'b01, 8'h5A, s);
        while (cyc < s + 4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (lcd_enable !== 1'b0 || lcd_data !== 8'd0) begin
            tests_failed++;
            $display("FAIL async_reset_pins: got E=%b data=%h expected E=0 data=00", lcd_enable, lcd_data);
        end
        repeat (3) @(negedge clk);
        release_and_check_init("rst_mid");
    endtask

    task automatic test_pending();
        int r;
        int e;
        int d;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        r       = cyc;
        id_rise = -1;
        clear_logs();
        model_init(r + PWR, e);
        model_write(e - 1, 1'b0, 8'h01, d);
        repeat ($urandom_range(5, 40)) @(negedge clk);
        issue(2'b00, 8'h01, r);
        while (cyc < d + 3) @(negedge clk);
        tests_run++;
        if (pq.size() != 5) begin
            tests_failed++;
            $display("FAIL pend_pulse_count: got %0d expected 5", pq.size());
        end
        for (int i = 0; i < pq.size() && i < 5; i++) begin
            tests_run++;
            if (pq[i].rise != epq[i].rise || pq[i].width != PULSE || pq[i].data !== epq[i].data || pq[i].rs !== 1'b0) begin
                tests_failed++;
                $display("FAIL pend_pulse%0d: got rise=%0d w=%0d data=%h rs=%b expected rise=%0d data=%h rs=0",
                         i, pq[i].rise, pq[i].width, pq[i].data, pq[i].rs, epq[i].rise, epq[i].data);
            end
        end
        tests_run++;
        if (dq.size() != 1 || dq[0].stamp != d || dq[0].res !== 32'h101) begin
            tests_failed++;
            $display("FAIL pend_done: got n=%0d stamp=%0d res=%h expected n=1 stamp=%0d res=00000101",
                     dq.size(), (dq.size() > 0) ? dq[0].stamp : -1, (dq.size() > 0) ? dq[0].res : 32'hx, d);
        end
    endtask

    initial begin
        rom[0] = 8'h38;
        rom[1] = 8'h0C;
        rom[2] = 8'h06;
        rom[3] = 8'h01;
        rst_n  = 1'b0;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = 32'd0;
        datab  = 32'd0;
        test_reset();
        test_init();
        test_write();
        test_status_reinit();
        test_random_writes();
        test_clk_en_freeze();
        test_reset_mid_pulse();
        test_pending();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
